// File: rtl/buffer_pkg.sv
// Shared types for the buffer sequencer: FSM states, bus owner encoding,
// and the width helper for the turnaround counter.
// Purely declarative; holds no logic or state.
package buffer_pkg;

  localparam int DEF_NUM_LANES   = 4;
  localparam int DEF_TURN_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    SETTLE,
    DRIVE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_LOCAL
  } owner_t;

  // The counter has to be able to hold the value turn_cycles itself.
  function automatic int cnt_width(input int turn_cycles);
    return (turn_cycles < 1) ? 1 : $clog2(turn_cycles + 1);
  endfunction

endpackage

// File: rtl/buf_turn_counter.sv
// Purpose: counts consecutive cycles in which every data buffer enable is off, saturating at TURN_CYCLES.
// Latency: count updates one edge after clear/inc; done is a decode of the registered count.
// Backpressure: none; inc and clear are sampled every cycle.
// Ports: clk, reset (sync, active high, loads the saturated value),
//        clear (some enable is on next cycle), inc (all enables off next cycle),
//        done (count >= TURN_CYCLES).
module buf_turn_counter #(
  parameter int TURN_CYCLES = 2,
  parameter int CNT_W       = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TURN_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Reset to the saturated value so a request straight out of reset does
  // not pay a turnaround: nothing has been driving.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= CNT_MAX;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !done) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done = (cnt >= CNT_MAX);

endmodule

// File: rtl/buffer_sequencer.sv
// Purpose: registered data/address buffer enable sequencer with dead time on every owner or direction change.
// Latency: from idle, BUFDIR one edge after the request, enables/BUF_RDY two edges after; DMAAn one edge.
// Backpressure: none; follows arbitration inputs every cycle, BUF_RDY flags when buffers are driving.
// Ports: CLK40, RESET (sync, active high), CPU_CYCLE, BBn, LBENn, RnW, LANE_EN[NUM_LANES]
//        -> CPUBGn, BUFENn[NUM_LANES] (active low), BUFDIR (1 = toward CPU), DMAAn, BUF_RDY.
module buffer_sequencer
  import buffer_pkg::*;
#(
  parameter int NUM_LANES   = DEF_NUM_LANES,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic                 CLK40,
  input  logic                 RESET,
  input  logic                 CPU_CYCLE,
  input  logic                 BBn,
  input  logic                 LBENn,
  input  logic                 RnW,
  input  logic [NUM_LANES-1:0] LANE_EN,
  output logic                 CPUBGn,
  output logic [NUM_LANES-1:0] BUFENn,
  output logic                 BUFDIR,
  output logic                 DMAAn,
  output logic                 BUF_RDY
);

  localparam int CNT_W = cnt_width(TURN_CYCLES);

  // Request decode
  logic   dma_en;
  owner_t own;
  logic   dir;

  assign dma_en = !BBn && !CPU_CYCLE;

  always_comb begin
    own = OWN_NONE;
    if (CPU_CYCLE) begin
      own = OWN_CPU;
    end else if (dma_en && !LBENn) begin
      own = OWN_LOCAL;
    end
  end

  assign dir = ((own == OWN_CPU) && RnW) || ((own == OWN_LOCAL) && !RnW);

  // FSM state and the owner/direction that BUFDIR was last set up for
  state_t state, state_nxt;
  owner_t own_l, own_l_nxt;
  logic   dir_l, dir_l_nxt;
  logic   target_match;

  logic                 bufdir_nxt;
  logic                 cpubgn_nxt;
  logic [NUM_LANES-1:0] bufenn_nxt;
  logic                 buf_rdy_nxt;

  logic cnt_clear;
  logic cnt_inc;
  logic off_done;

  assign target_match = (own == own_l) && (dir == dir_l);

  always_comb begin
    state_nxt   = state;
    own_l_nxt   = own_l;
    dir_l_nxt   = dir_l;
    bufdir_nxt  = BUFDIR;
    cpubgn_nxt  = 1'b1;
    bufenn_nxt  = '1;
    buf_rdy_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (own != OWN_NONE) begin
          if (off_done) begin
            state_nxt  = SETTLE;
            own_l_nxt  = own;
            dir_l_nxt  = dir;
            bufdir_nxt = dir;
          end else begin
            state_nxt = TURN;
          end
        end
      end

      // Changes of request while waiting are ignored; only the request
      // present when the dead time expires is set up.
      TURN: begin
        if (off_done) begin
          if (own == OWN_NONE) begin
            state_nxt = IDLE;
          end else begin
            state_nxt  = SETTLE;
            own_l_nxt  = own;
            dir_l_nxt  = dir;
            bufdir_nxt = dir;
          end
        end
      end

      // BUFDIR has had one cycle to propagate; enable only if the request
      // still matches what it was set up for, otherwise re-aim and wait again.
      SETTLE: begin
        if (own == OWN_NONE) begin
          state_nxt = IDLE;
        end else if (target_match) begin
          state_nxt   = DRIVE;
          bufenn_nxt  = ~LANE_EN;
          cpubgn_nxt  = (own_l != OWN_CPU);
          buf_rdy_nxt = 1'b1;
        end else begin
          own_l_nxt  = own;
          dir_l_nxt  = dir;
          bufdir_nxt = dir;
        end
      end

      DRIVE: begin
        if (own == OWN_NONE) begin
          state_nxt = IDLE;
        end else if (!target_match) begin
          state_nxt = TURN;
        end else begin
          bufenn_nxt  = ~LANE_EN;
          cpubgn_nxt  = (own_l != OWN_CPU);
          buf_rdy_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The counter tracks the enables as they will be after this edge, so
  // its registered value is the number of dead cycles already on the pins.
  assign cnt_clear = !(cpubgn_nxt && (&bufenn_nxt));
  assign cnt_inc   = !cnt_clear;

  buf_turn_counter #(
    .TURN_CYCLES (TURN_CYCLES),
    .CNT_W       (CNT_W)
  ) u_turn_counter (
    .clk   (CLK40),
    .reset (RESET),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .done  (off_done)
  );

  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state   <= IDLE;
      own_l   <= OWN_NONE;
      dir_l   <= 1'b0;
      BUFDIR  <= 1'b0;
      CPUBGn  <= 1'b1;
      BUFENn  <= '1;
      BUF_RDY <= 1'b0;
      DMAAn   <= 1'b1;
    end else begin
      state   <= state_nxt;
      own_l   <= own_l_nxt;
      dir_l   <= dir_l_nxt;
      BUFDIR  <= bufdir_nxt;
      CPUBGn  <= cpubgn_nxt;
      BUFENn  <= bufenn_nxt;
      BUF_RDY <= buf_rdy_nxt;
      // Address buffer follows DMA ownership directly, no dead time.
      DMAAn   <= !dma_en;
    end
  end

endmodule
